// File: rtl/alu_seq_param.sv
// Multi-cycle word-serial ALU: add, sub, signed radix-4 Booth multiply, unsigned non-restoring divide.
// Operands arrive one word per cycle on inbus; results leave on outbus, END pulses after the last word.
module alu_seq_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BEGIN,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             out_valid,
    output logic             END,
    output logic             busy,
    output logic             ovf,
    output logic             dbz
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned AW = WIDTH + 2;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("alu_seq_param: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_X, S_LOAD_Y, S_LOAD_M, S_CALC, S_OUT_HI, S_OUT_LO, S_DONE
    } state_t;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t           state_q, state_d;
    op_t              op_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] q_q;
    logic [AW-1:0]    a_q;
    logic             qm1_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q, dbz_q;

    logic [CW-1:0]    cnt_last;
    logic             div_err;
    logic [WIDTH-1:0] as_res;
    logic             as_ovf;
    logic [AW-1:0]    m_ext, pp, booth_sum;
    logic [AW-1:0]    d_ext, shl, nr_rem;

    always_comb begin
        cnt_last = '0;
        case (op_q)
            OP_MUL:  cnt_last = CW'(WIDTH / 2 - 1);
            OP_DIV:  cnt_last = CW'(WIDTH);
            default: cnt_last = '0;
        endcase
    end

    assign div_err = (inbus == '0) || (a_q[WIDTH-1:0] >= inbus);

    // add/sub result and signed overflow
    always_comb begin
        as_res = '0;
        as_ovf = 1'b0;
        if (op_q == OP_SUB) begin
            as_res = x_q - q_q;
            as_ovf = (x_q[WIDTH-1] != q_q[WIDTH-1]) && (as_res[WIDTH-1] != x_q[WIDTH-1]);
        end else begin
            as_res = x_q + q_q;
            as_ovf = (x_q[WIDTH-1] == q_q[WIDTH-1]) && (as_res[WIDTH-1] != x_q[WIDTH-1]);
        end
    end

    // Booth digit: accumulator carries two guard bits so +-2M never wraps before the shift
    assign m_ext = {{2{x_q[WIDTH-1]}}, x_q};
    always_comb begin
        pp = '0;
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100:         pp = (~(m_ext << 1)) + AW'(1);
            3'b101, 3'b110: pp = (~m_ext) + AW'(1);
            default:        pp = '0;
        endcase
    end
    assign booth_sum = a_q + pp;

    // non-restoring step: sign of the partial remainder picks add or subtract
    assign d_ext  = {2'b00, x_q};
    assign shl    = {a_q[AW-2:0], q_q[WIDTH-1]};
    assign nr_rem = a_q[AW-1] ? (shl + d_ext) : (shl - d_ext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        out_valid = 1'b0;
        END       = 1'b0;
        outbus    = '0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (BEGIN) state_d = S_LOAD_X;
            end
            S_LOAD_X: state_d = S_LOAD_Y;
            S_LOAD_Y: state_d = (op_q == OP_DIV) ? S_LOAD_M : S_CALC;
            S_LOAD_M: state_d = div_err ? S_OUT_HI : S_CALC;
            S_CALC: begin
                if (cnt_q == cnt_last)
                    state_d = (op_q == OP_MUL || op_q == OP_DIV) ? S_OUT_HI : S_OUT_LO;
            end
            S_OUT_HI: begin
                out_valid = 1'b1;
                outbus    = a_q[WIDTH-1:0];
                state_d   = S_OUT_LO;
            end
            S_OUT_LO: begin
                out_valid = 1'b1;
                outbus    = q_q;
                state_d   = S_DONE;
            end
            S_DONE: begin
                END     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= OP_ADD;
            x_q   <= '0;
            q_q   <= '0;
            a_q   <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            dbz_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (BEGIN) op_q <= op_t'(op_code);
                end
                S_LOAD_X: begin
                    if (op_q == OP_DIV) a_q <= {2'b00, inbus};
                    else                x_q <= inbus;
                end
                S_LOAD_Y: begin
                    q_q   <= inbus;
                    qm1_q <= 1'b0;
                    cnt_q <= '0;
                    if (op_q != OP_DIV) a_q <= '0;
                end
                S_LOAD_M: begin
                    x_q   <= inbus;
                    cnt_q <= '0;
                    if (inbus == '0)                        dbz_q <= 1'b1;
                    else if (a_q[WIDTH-1:0] >= inbus)       ovf_q <= 1'b1;
                    if (div_err) begin
                        a_q <= '0;
                        q_q <= '0;
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + CW'(1);
                    case (op_q)
                        OP_MUL: begin
                            a_q   <= {booth_sum[AW-1], booth_sum[AW-1], booth_sum[AW-1:2]};
                            q_q   <= {booth_sum[1:0], q_q[WIDTH-1:2]};
                            qm1_q <= q_q[1];
                        end
                        OP_DIV: begin
                            if (cnt_q != CW'(WIDTH)) begin
                                a_q <= nr_rem;
                                q_q <= {q_q[WIDTH-2:0], ~nr_rem[AW-1]};
                            end else if (a_q[AW-1]) begin
                                a_q <= a_q + d_ext;
                            end
                        end
                        default: begin
                            q_q   <= as_res;
                            ovf_q <= as_ovf;
                        end
                    endcase
                end
                S_DONE: begin
                    ovf_q <= 1'b0;
                    dbz_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ovf = ovf_q;
    assign dbz = dbz_q;

endmodule
